// File: rtl/decode_10bto8b_if.sv
// Receive-side 8b/10b decoder bus: symbol handshake from the deserializer
// and decoded-byte strobe towards the frame parser.
interface decode_10bto8b_if;
    logic       decode_en;
    logic [9:0] data_10b;
    logic       data_10b_en;
    logic [7:0] data_8b;
    logic       data_8b_en;
    logic       code_err;
    logic       disp_err;
    logic       decode_load_data_flag;
    logic       overrun;
    logic       rd;

    modport master (
        output decode_en, data_10b, data_10b_en,
        input  data_8b, data_8b_en, code_err, disp_err,
        input  decode_load_data_flag, overrun, rd
    );

    modport slave (
        input  decode_en, data_10b, data_10b_en,
        output data_8b, data_8b_en, code_err, disp_err,
        output decode_load_data_flag, overrun, rd
    );
endinterface

// File: rtl/decode_10bto8b.sv
// 8b/10b symbol decoder for one received frame: 6b/5b then 4b/3b lookup with
// running-disparity tracking, code/disparity error flags and a byte strobe.
module decode_10bto8b (
    input  logic            clk,
    input  logic            rst,
    decode_10bto8b_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAITING,
        DECODE_6B_5B,
        DECODE_4B_3B,
        DATA_8B_OUT
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] value;
    } code6_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] value;
    } code4_t;

    typedef struct packed {
        logic err;
        logic rd;
    } disp_t;

    // Both RD forms of every 6b code map to the same 5-bit value.
    function automatic code6_t lookup_6b(input logic [5:0] p);
        code6_t r;
        r.valid = 1'b1;
        r.value = 5'd0;
        case (p)
            6'b111001, 6'b000110: r.value = 5'd0;
            6'b101110, 6'b010001: r.value = 5'd1;
            6'b101101, 6'b010010: r.value = 5'd2;
            6'b100011:            r.value = 5'd3;
            6'b101011, 6'b010100: r.value = 5'd4;
            6'b100101:            r.value = 5'd5;
            6'b100110:            r.value = 5'd6;
            6'b000111, 6'b111000: r.value = 5'd7;
            6'b100111, 6'b011000: r.value = 5'd8;
            6'b101001:            r.value = 5'd9;
            6'b101010:            r.value = 5'd10;
            6'b001011:            r.value = 5'd11;
            6'b101100:            r.value = 5'd12;
            6'b001101:            r.value = 5'd13;
            6'b001110:            r.value = 5'd14;
            6'b111010, 6'b000101: r.value = 5'd15;
            6'b110110, 6'b001001: r.value = 5'd16;
            6'b110001:            r.value = 5'd17;
            6'b110010:            r.value = 5'd18;
            6'b010011:            r.value = 5'd19;
            6'b110100:            r.value = 5'd20;
            6'b010101:            r.value = 5'd21;
            6'b010110:            r.value = 5'd22;
            6'b010111, 6'b101000: r.value = 5'd23;
            6'b110011, 6'b001100: r.value = 5'd24;
            6'b011001:            r.value = 5'd25;
            6'b011010:            r.value = 5'd26;
            6'b011011, 6'b100100: r.value = 5'd27;
            6'b011100:            r.value = 5'd28;
            6'b011101, 6'b100010: r.value = 5'd29;
            6'b011110, 6'b100001: r.value = 5'd30;
            6'b110101, 6'b001010: r.value = 5'd31;
            default:              r.valid = 1'b0;
        endcase
        return r;
    endfunction

    // Value 7 has four encodings: P7/A7 in each running disparity.
    function automatic code4_t lookup_4b(input logic [3:0] p);
        code4_t r;
        r.valid = 1'b1;
        r.value = 3'd0;
        case (p)
            4'b1101, 4'b0010:                   r.value = 3'd0;
            4'b1001:                            r.value = 3'd1;
            4'b1010:                            r.value = 3'd2;
            4'b0011, 4'b1100:                   r.value = 3'd3;
            4'b1011, 4'b0100:                   r.value = 3'd4;
            4'b0101:                            r.value = 3'd5;
            4'b0110:                            r.value = 3'd6;
            4'b0111, 4'b1000, 4'b1110, 4'b0001: r.value = 3'd7;
            default:                            r.valid = 1'b0;
        endcase
        return r;
    endfunction

    // Same rule for both sub-blocks; only the weight thresholds and the two
    // RD-restricted neutral patterns differ.
    function automatic disp_t disparity_rule(
        input logic rd_in,
        input logic positive,
        input logic negative,
        input logic neutral_minus_only,
        input logic neutral_plus_only
    );
        disp_t r;
        r.rd  = rd_in;
        r.err = 1'b0;
        if (positive) begin
            r.err = rd_in;
            r.rd  = 1'b1;
        end else if (negative) begin
            r.err = !rd_in;
            r.rd  = 1'b0;
        end else begin
            r.err = (neutral_minus_only && rd_in) || (neutral_plus_only && !rd_in);
        end
        return r;
    endfunction

    state_e     state_q, state_d;
    logic [9:0] sym_q, sym_d;
    logic [4:0] val5_q, val5_d;
    logic [2:0] val3_q, val3_d;
    logic       rd_q, rd_d;
    logic       code_err_q, code_err_d;
    logic       disp_err_q, disp_err_d;
    logic [7:0] data_8b_q, data_8b_d;
    logic       data_8b_en_q, data_8b_en_d;
    logic       load_flag_q, load_flag_d;
    logic       overrun_q, overrun_d;

    code6_t     code6;
    code4_t     code4;
    disp_t      disp6;
    disp_t      disp4;

    // rd_q already holds the post-6b disparity while in DECODE_4B_3B.
    always_comb begin
        code6 = lookup_6b(sym_q[5:0]);
        code4 = lookup_4b(sym_q[9:6]);
        disp6 = disparity_rule(rd_q,
                               $countones(sym_q[5:0]) == 4,
                               $countones(sym_q[5:0]) == 2,
                               sym_q[5:0] == 6'b000111,
                               sym_q[5:0] == 6'b111000);
        disp4 = disparity_rule(rd_q,
                               $countones(sym_q[9:6]) == 3,
                               $countones(sym_q[9:6]) == 1,
                               sym_q[9:6] == 4'b0011,
                               sym_q[9:6] == 4'b1100);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:         state_d = WAITING;
            WAITING:      if (bus.data_10b_en) state_d = DECODE_6B_5B;
            DECODE_6B_5B: state_d = DECODE_4B_3B;
            DECODE_4B_3B: state_d = DATA_8B_OUT;
            DATA_8B_OUT:  state_d = WAITING;
            default:      state_d = IDLE;
        endcase
        if (!bus.decode_en) begin
            state_d = IDLE;
        end
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        sym_d        = sym_q;
        val5_d       = val5_q;
        val3_d       = val3_q;
        rd_d         = rd_q;
        code_err_d   = code_err_q;
        disp_err_d   = disp_err_q;
        data_8b_d    = data_8b_q;
        data_8b_en_d = 1'b0;
        load_flag_d  = 1'b0;
        overrun_d    = bus.data_10b_en && (state_q != WAITING);

        unique case (state_q)
            WAITING: begin
                if (bus.data_10b_en) begin
                    sym_d       = bus.data_10b;
                    load_flag_d = 1'b1;
                end
            end
            DECODE_6B_5B: begin
                val5_d     = code6.value;
                code_err_d = !code6.valid;
                disp_err_d = code6.valid && disp6.err;
                if (code6.valid) begin
                    rd_d = disp6.rd;
                end
            end
            DECODE_4B_3B: begin
                val3_d     = code4.value;
                code_err_d = code_err_q || !code4.valid;
                disp_err_d = disp_err_q || (code4.valid && disp4.err);
                if (code4.valid) begin
                    rd_d = disp4.rd;
                end
            end
            DATA_8B_OUT: begin
                data_8b_d    = {val3_q, val5_q};
                data_8b_en_d = 1'b1;
            end
            default: ;
        endcase

        // A dropped enable clears the frame exactly like reset; next frame starts at RD-.
        if (!bus.decode_en) begin
            sym_d        = '0;
            val5_d       = '0;
            val3_d       = '0;
            rd_d         = 1'b0;
            code_err_d   = 1'b0;
            disp_err_d   = 1'b0;
            data_8b_d    = '0;
            data_8b_en_d = 1'b0;
            load_flag_d  = 1'b0;
            overrun_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sym_q        <= '0;
            val5_q       <= '0;
            val3_q       <= '0;
            rd_q         <= 1'b0;
            code_err_q   <= 1'b0;
            disp_err_q   <= 1'b0;
            data_8b_q    <= '0;
            data_8b_en_q <= 1'b0;
            load_flag_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sym_q        <= sym_d;
            val5_q       <= val5_d;
            val3_q       <= val3_d;
            rd_q         <= rd_d;
            code_err_q   <= code_err_d;
            disp_err_q   <= disp_err_d;
            data_8b_q    <= data_8b_d;
            data_8b_en_q <= data_8b_en_d;
            load_flag_q  <= load_flag_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.data_8b               = data_8b_q;
    assign bus.data_8b_en            = data_8b_en_q;
    assign bus.code_err              = code_err_q;
    assign bus.disp_err              = disp_err_q;
    assign bus.decode_load_data_flag = load_flag_q;
    assign bus.overrun               = overrun_q;
    assign bus.rd                    = rd_q;

endmodule

// File: tb/tb_decode_10bto8b.sv
// Self-checking bench for decode_10bto8b: directed symbols with literal
// expectations plus a table-driven reference model checked at every byte strobe.
module tb_decode_10bto8b;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_10bto8b_if bus ();

    decode_10bto8b dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       code_err;
        logic       disp_err;
        logic       rd_mid;
        logic       rd_out;
    } exp_t;

    typedef struct packed {
        logic [9:0] sym;
        logic [7:0] data;
        logic       code_err;
        logic       disp_err;
        logic       rd;
        logic [2:0] trace;
    } vec_t;

    // Forward code tables in RD- form, value order.
    localparam logic [5:0] T6 [32] = '{
        6'b111001, 6'b101110, 6'b101101, 6'b100011, 6'b101011, 6'b100101, 6'b100110, 6'b000111,
        6'b100111, 6'b101001, 6'b101010, 6'b001011, 6'b101100, 6'b001101, 6'b001110, 6'b111010,
        6'b110110, 6'b110001, 6'b110010, 6'b010011, 6'b110100, 6'b010101, 6'b010110, 6'b010111,
        6'b110011, 6'b011001, 6'b011010, 6'b011011, 6'b011100, 6'b011101, 6'b011110, 6'b110101
    };
    localparam logic [3:0] T4 [8] = '{
        4'b1101, 4'b1001, 4'b1010, 4'b0011, 4'b1011, 4'b0101, 4'b0110, 4'b0111
    };
    localparam logic [3:0] A7 = 4'b1110;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t sb_exp;
    logic model_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Searches the forward tables for the received pattern, then applies the
    // weight/RD legality rules sub-block by sub-block.
    function automatic exp_t model(input logic [9:0] sym, input logic rd_in);
        exp_t       r;
        logic [5:0] p6;
        logic [3:0] p4;
        logic [4:0] v6;
        logic [2:0] v3;
        logic       found;
        logic       rd;
        int         w;
        r  = '0;
        p6 = sym[5:0];
        p4 = sym[9:6];
        rd = rd_in;

        found = 1'b0;
        v6    = '0;
        for (int v = 0; v < 32; v++) begin
            if (p6 == T6[v]) begin found = 1'b1; v6 = 5'(v); end
            if (($countones(T6[v]) != 3 || v == 7) && p6 == ~T6[v]) begin found = 1'b1; v6 = 5'(v); end
        end
        w = $countones(p6);
        if (!found) r.code_err = 1'b1;
        else if (w == 4) begin r.disp_err = rd; rd = 1'b1; end
        else if (w == 2) begin r.disp_err = !rd; rd = 1'b0; end
        else if ((p6 == 6'b000111 && rd) || (p6 == 6'b111000 && !rd)) r.disp_err = 1'b1;
        r.rd_mid = rd;

        found = 1'b0;
        v3    = '0;
        for (int v = 0; v < 8; v++) begin
            if (p4 == T4[v]) begin found = 1'b1; v3 = 3'(v); end
            if ((v == 0 || v == 3 || v == 4 || v == 7) && p4 == ~T4[v]) begin found = 1'b1; v3 = 3'(v); end
        end
        if (p4 == A7 || p4 == ~A7) begin found = 1'b1; v3 = 3'd7; end
        w = $countones(p4);
        if (!found) r.code_err = 1'b1;
        else if (w == 3) begin r.disp_err = r.disp_err | rd; rd = 1'b1; end
        else if (w == 1) begin r.disp_err = r.disp_err | !rd; rd = 1'b0; end
        else if ((p4 == 4'b0011 && rd) || (p4 == 4'b1100 && !rd)) r.disp_err = 1'b1;

        r.data   = {v3, v6};
        r.rd_out = rd;
        return r;
    endfunction

    // Scoreboard: every byte strobe must match the oldest outstanding symbol.
    always @(negedge clk) begin
        if (bus.data_8b_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("strobe_without_symbol", 32'(bus.data_8b_en), 32'd0);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_data", 32'(bus.data_8b), 32'(sb_exp.data));
                check("sb_code_err", 32'(bus.code_err), 32'(sb_exp.code_err));
                check("sb_disp_err", 32'(bus.disp_err), 32'(sb_exp.disp_err));
                check("sb_rd", 32'(bus.rd), 32'(sb_exp.rd_out));
            end
        end
    end

    // Presents one symbol in WAITING and returns at the negedge carrying the strobe.
    task automatic send(input logic [9:0] sym, output int lat, output logic [2:0] trace);
        exp_t m;
        m        = model(sym, model_rd);
        model_rd = m.rd_out;
        exp_q.push_back(m);
        bus.data_10b    = sym;
        bus.data_10b_en = 1'b1;
        @(negedge clk);
        bus.data_10b_en = 1'b0;
        check("load_flag", 32'(bus.decode_load_data_flag), 32'd1);
        trace    = '0;
        trace[0] = bus.rd;
        lat      = 0;
        while (bus.data_8b_en !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
            if (lat == 1) trace[1] = bus.rd;
            if (lat == 2) trace[2] = bus.rd;
        end
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        while (bus.data_8b_en !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
    endtask

    function automatic logic [13:0] all_outputs();
        return {bus.data_8b, bus.data_8b_en, bus.code_err, bus.disp_err,
                bus.decode_load_data_flag, bus.overrun, bus.rd};
    endfunction

    vec_t vecs [9];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         lat;
        int         n;
        int         strobes;
        logic [2:0] tr;
        exp_t       m;

        vecs[0] = '{10'b0010111001, 8'h00, 1'b0, 1'b0, 1'b0, 3'b010};
        vecs[1] = '{10'b1101100011, 8'h03, 1'b0, 1'b0, 1'b1, 3'b100};
        vecs[2] = '{10'b0111001010, 8'hFF, 1'b0, 1'b0, 1'b1, 3'b101};
        vecs[3] = '{10'b0010111001, 8'h00, 1'b0, 1'b1, 1'b0, 3'b011};
        vecs[4] = '{10'b0000000000, 8'h00, 1'b1, 1'b0, 1'b0, 3'b000};
        vecs[5] = '{10'b0101000111, 8'hA7, 1'b0, 1'b0, 1'b0, 3'b000};
        vecs[6] = '{10'b1100111000, 8'h67, 1'b0, 1'b1, 1'b0, 3'b000};
        vecs[7] = '{10'b1110101011, 8'hE4, 1'b0, 1'b1, 1'b1, 3'b110};
        vecs[8] = '{10'b0001111100, 8'hE0, 1'b1, 1'b0, 1'b0, 3'b011};

        rst             = 1'b1;
        bus.decode_en   = 1'b1;
        bus.data_10b    = '0;
        bus.data_10b_en = 1'b0;
        model_rd        = 1'b0;

        // Model pins against hand-derived results.
        m = model(10'b0010111001, 1'b0);
        check("pin_k_data", 32'(m.data), 32'h00);
        check("pin_k_rd_mid", 32'(m.rd_mid), 32'd1);
        check("pin_k_rd_out", 32'(m.rd_out), 32'd0);
        m = model(10'b0010111001, 1'b1);
        check("pin_rdp_disp", 32'(m.disp_err), 32'd1);
        m = model(10'b0111001010, 1'b1);
        check("pin_ff_data", 32'(m.data), 32'hFF);
        m = model(10'b0000000000, 1'b0);
        check("pin_zero_code", 32'(m.code_err), 32'd1);

        @(negedge clk);
        check("reset_data_8b", 32'(bus.data_8b), 32'h00);
        check("reset_data_8b_en", 32'(bus.data_8b_en), 32'd0);
        check("reset_code_err", 32'(bus.code_err), 32'd0);
        check("reset_disp_err", 32'(bus.disp_err), 32'd0);
        check("reset_load_flag", 32'(bus.decode_load_data_flag), 32'd0);
        check("reset_overrun", 32'(bus.overrun), 32'd0);
        check("reset_rd", 32'(bus.rd), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            send(vecs[i].sym, lat, tr);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
            check($sformatf("v%0d_rd_trace", i), 32'(tr), 32'(vecs[i].trace));
            check($sformatf("v%0d_data", i), 32'(bus.data_8b), 32'(vecs[i].data));
            check($sformatf("v%0d_code_err", i), 32'(bus.code_err), 32'(vecs[i].code_err));
            check($sformatf("v%0d_disp_err", i), 32'(bus.disp_err), 32'(vecs[i].disp_err));
            check($sformatf("v%0d_rd", i), 32'(bus.rd), 32'(vecs[i].rd));
        end

        // Abort in DECODE_4B_3B: no strobe, everything cleared, RD back to RD-.
        bus.data_10b    = 10'b0010111001;
        bus.data_10b_en = 1'b1;
        @(negedge clk);
        bus.data_10b_en = 1'b0;
        @(negedge clk);
        check("abort_rd_mid", 32'(bus.rd), 32'd1);
        bus.decode_en = 1'b0;
        @(negedge clk);
        check("abort_outputs", 32'(all_outputs()), 32'd0);
        model_rd = 1'b0;
        @(negedge clk);
        bus.decode_en = 1'b1;
        @(negedge clk);

        send(10'b0111001010, lat, tr);
        check("restart_latency", 32'(lat), 32'd3);
        check("restart_data", 32'(bus.data_8b), 32'hFF);
        check("restart_disp_err", 32'(bus.disp_err), 32'd1);
        check("restart_rd", 32'(bus.rd), 32'd1);

        // Reset mid-frame right after the capture edge.
        bus.data_10b    = 10'b1101100011;
        bus.data_10b_en = 1'b1;
        @(negedge clk);
        bus.data_10b_en = 1'b0;
        rst             = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_outputs", 32'(all_outputs()), 32'd0);
        model_rd = 1'b0;
        @(negedge clk);

        // Second strobe one cycle after capture is dropped.
        m        = model(10'b1101100011, model_rd);
        model_rd = m.rd_out;
        exp_q.push_back(m);
        bus.data_10b    = 10'b1101100011;
        bus.data_10b_en = 1'b1;
        @(negedge clk);
        check("ovr_load_flag", 32'(bus.decode_load_data_flag), 32'd1);
        bus.data_10b = 10'b0000000000;
        @(negedge clk);
        bus.data_10b_en = 1'b0;
        check("ovr_pulse", 32'(bus.overrun), 32'd1);
        @(negedge clk);
        check("ovr_pulse_end", 32'(bus.overrun), 32'd0);
        wait_strobe(n);
        check("ovr_strobe_seen", 32'(bus.data_8b_en), 32'd1);
        check("ovr_data", 32'(bus.data_8b), 32'h03);
        check("ovr_code_err", 32'(bus.code_err), 32'd0);
        strobes = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.data_8b_en === 1'b1) strobes++;
        end
        check("ovr_single_strobe", 32'(strobes), 32'd0);
        check("data_hold", 32'(bus.data_8b), 32'h03);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
